// File: rtl/i2c_pkg.sv
// Shared constants for the I2C core: FIFO defaults and the status-bit map
// used by both the FIFOs and the APB register block.
package i2c_pkg;

  localparam int I2C_DATA_W     = 8;
  localparam int I2C_FIFO_DEPTH = 16;
  localparam int I2C_FIFO_AF    = 14;
  localparam int I2C_FIFO_AE    = 2;

  // Bit positions of the FIFO status word as seen by the APB register map.
  typedef enum logic [2:0] {
    EMPTY  = 3'd0,
    FULL   = 3'd1,
    AFULL  = 3'd2,
    AEMPTY = 3'd3,
    OVF    = 3'd4,
    UDF    = 3'd5
  } i2c_status_idx_e;

  localparam int I2C_STATUS_W = 6;

endpackage

// File: rtl/i2c_fifo_param.sv
// Parametrised synchronous FIFO with level, threshold flags, sticky errors and flush.
// Optional high-water mark register enabled by defining I2C_FIFO_PEAK_LEVEL_EN.
module i2c_fifo_param
  import i2c_pkg::*;
#(
  parameter int DATA_W   = I2C_DATA_W,
  parameter int DEPTH    = I2C_FIFO_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = I2C_FIFO_AE,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AW:0]       level,
  output logic              overflow,
  output logic              underflow,
  output logic [AW:0]       peak_level
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("i2c_fifo_param: DEPTH must be a power of two and at least 2");
  end
  if (AF_LEVEL < 0 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL > DEPTH) begin : g_bad_level
    $error("i2c_fifo_param: AF_LEVEL/AE_LEVEL must lie in 0..DEPTH");
  end

  localparam logic [AW:0] DEPTH_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_LVL    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_LVL    = (AW+1)'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       level_q, level_nxt;
  logic              rd_acc, wr_acc;
  logic              ovf_q, udf_q;

  assign empty        = (level_q == '0);
  assign full         = (level_q == DEPTH_LVL);
  assign almost_full  = (level_q >= AF_LVL);
  assign almost_empty = (level_q <= AE_LVL);
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rd_acc = rd & ~empty;
  assign wr_acc = wr & (~full | rd_acc);

  // NOTE: level_nxt gets its default before any branch, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    level_nxt = level_q;
    if (flush) begin
      level_nxt = '0;
    end else begin
      unique case ({wr_acc, rd_acc})
        2'b10:   level_nxt = level_q + 1'b1;
        2'b01:   level_nxt = level_q - 1'b1;
        default: level_nxt = level_q;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      data_out <= '0;
      rd_valid <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      rd_valid <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      level_q  <= level_nxt;
      rd_valid <= rd_acc;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      if (wr && !wr_acc) ovf_q <= 1'b1;
      if (rd && !rd_acc) udf_q <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; pointers and level define which
  // entries are meaningful, so resetting it would only cost area and timing.
  always_ff @(posedge clk) begin
    if (wr_acc && !flush) mem[wr_ptr] <= data_in;
  end

`ifdef I2C_FIFO_PEAK_LEVEL_EN
  logic [AW:0] peak_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_q <= '0;
    end else if (flush) begin
      peak_q <= '0;
    end else if (level_nxt > peak_q) begin
      peak_q <= level_nxt;
    end
  end

  assign peak_level = peak_q;
`else
  assign peak_level = '0;
`endif

endmodule

// File: tb/tb_i2c_fifo_param.sv
// Self-checking bench for i2c_fifo_param (DEPTH=4, AF_LEVEL=3, AE_LEVEL=1):
// directed steps followed by random traffic, compared against a queue model.
module tb_i2c_fifo_param;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AFL   = 3;
  localparam int AEL   = 1;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          rd_valid, full, empty, almost_full, almost_empty;
  logic [AW:0]   level, peak_level;
  logic          overflow, underflow;

  i2c_fifo_param #(
    .DATA_W  (DW),
    .DEPTH   (DEPTH),
    .AF_LEVEL(AFL),
    .AE_LEVEL(AEL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wr          (wr),
    .data_in     (data_in),
    .rd          (rd),
    .data_out    (data_out),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .level       (level),
    .overflow    (overflow),
    .underflow   (underflow),
    .peak_level  (peak_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: contents as a queue plus the observable registers.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout;
  logic          m_rv, m_ovf, m_udf;
  int            m_peak;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout = '0;
    m_rv   = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_peak = 0;
  endtask

  task automatic model_step(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
    bit ra, wa;
    if (f) begin
      mq.delete();
      m_rv   = 1'b0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_peak = 0;
    end else begin
      ra = r && (mq.size() > 0);
      wa = w && ((mq.size() < DEPTH) || ra);
      if (ra) m_dout = mq.pop_front();
      m_rv = ra;
      if (wa) mq.push_back(d);
      if (w && !wa) m_ovf = 1'b1;
      if (r && !ra) m_udf = 1'b1;
      if (mq.size() > m_peak) m_peak = mq.size();
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".level"},        32'(level),        32'(n));
    chk({tag, ".empty"},        32'(empty),        32'(n == 0));
    chk({tag, ".full"},         32'(full),         32'(n == DEPTH));
    chk({tag, ".almost_full"},  32'(almost_full),  32'(n >= AFL));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= AEL));
    chk({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
    chk({tag, ".underflow"},    32'(underflow),    32'(m_udf));
    chk({tag, ".rd_valid"},     32'(rd_valid),     32'(m_rv));
    chk({tag, ".data_out"},     32'(data_out),     32'(m_dout));
`ifdef I2C_FIFO_PEAK_LEVEL_EN
    chk({tag, ".peak_level"},   32'(peak_level),   32'(m_peak));
`else
    chk({tag, ".peak_level"},   32'(peak_level),   32'(0));
`endif
  endtask

  // One clock: drive inputs, take the edge, update the model, compare.
  task automatic step(input string tag, input logic w, input logic [DW-1:0] d,
                      input logic r, input logic f);
    wr = w; data_in = d; rd = r; flush = f;
    @(posedge clk);
    #1;
    model_step(w, d, r, f);
    check_all(tag);
  endtask

  initial begin
    logic [DW-1:0] seq [4];
    seq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    model_reset();

    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;
    step("idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // Fill with four words, then drain them in order
    for (int i = 0; i < 4; i++) step($sformatf("fill%0d", i), 1'b1, seq[i], 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step($sformatf("drain%0d", i), 1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain.last_word", 32'(data_out), 32'h0000_00D4);
    step("drain.idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // Full FIFO: simultaneous wr+rd succeeds, lone write overflows
    for (int i = 0; i < 4; i++) step($sformatf("refill%0d", i), 1'b1, seq[i], 1'b0, 1'b0);
    step("full_wr_rd", 1'b1, 8'hEE, 1'b1, 1'b0);
    chk("full_wr_rd.first_out", 32'(data_out), 32'h0000_00A1);
    step("full_lone_wr", 1'b1, 8'h77, 1'b0, 1'b0);

    // Empty FIFO: simultaneous wr+rd writes, rejects the read, no bypass
    step("pre_empty_flush", 1'b0, 8'h00, 1'b0, 1'b1);
    step("empty_wr_rd", 1'b1, 8'h55, 1'b1, 1'b0);
    step("empty_rd_next", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("empty_rd_next.value", 32'(data_out), 32'h0000_0055);

    // Wrap-around: ten words through the FIFO at low occupancy
    step("wrap_flush", 1'b0, 8'h00, 1'b0, 1'b1);
    step("wrap_w0", 1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) step($sformatf("wrap%0d", i), 1'b1, 8'(i), 1'b1, 1'b0);
    step("wrap_last", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("wrap_last.value", 32'(data_out), 32'h0000_0009);

    // Flush at level 3 with overflow set, a write in the same cycle is dropped
    for (int i = 0; i < 4; i++) step($sformatf("pf_fill%0d", i), 1'b1, seq[i], 1'b0, 1'b0);
    step("pf_ovf", 1'b1, 8'h99, 1'b0, 1'b0);
    step("pf_rd", 1'b0, 8'h00, 1'b1, 1'b0);
    step("pf_flush", 1'b1, 8'h66, 1'b0, 1'b1);
    step("pf_after", 1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset taken mid-cycle, away from any clock edge
    step("ar_w0", 1'b1, 8'h31, 1'b0, 1'b0);
    step("ar_w1", 1'b1, 8'h32, 1'b1, 1'b0);
    wr = 1'b0; rd = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    check_all("async_reset_held");

    // Random traffic with a bias that alternates between filling and draining
    for (int i = 0; i < 600; i++) begin
      int bias;
      logic w, r, f;
      bias = ((i / 40) % 2 == 0) ? 3 : 1;
      w = ($urandom_range(0, 3) < bias);
      r = ($urandom_range(0, 3) < 4 - bias);
      f = ($urandom_range(0, 63) == 0);
      step($sformatf("rand%0d", i), w, 8'($urandom), r, f);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
